// File: rtl/otter_perf_pkg.sv
// Shared definitions for the OTTER performance monitor: register map, FSM states,
// counter indices and trace depth.
package otter_perf_pkg;

  localparam logic [5:0] OFF_CTRL    = 6'h00;
  localparam logic [5:0] OFF_WATCH   = 6'h04;
  localparam logic [5:0] OFF_LIMIT   = 6'h08;
  localparam logic [5:0] OFF_CYCLES  = 6'h0C;
  localparam logic [5:0] OFF_STALLS  = 6'h10;
  localparam logic [5:0] OFF_FLUSHES = 6'h14;
  localparam logic [5:0] OFF_HITS    = 6'h18;
  localparam logic [5:0] OFF_STATUS  = 6'h1C;

  localparam int TRACE_DEPTH = 8;

  // Order of the saturating counters inside the top-level counter array
  localparam int NUM_CNT     = 4;
  localparam int CNT_CYCLES  = 0;
  localparam int CNT_STALLS  = 1;
  localparam int CNT_FLUSHES = 2;
  localparam int CNT_HITS    = 3;

  typedef enum logic [1:0] {
    DISABLED = 2'b00,
    RUNNING  = 2'b01,
    FROZEN   = 2'b10
  } perf_state_t;

endpackage

// File: rtl/perf_trace_buf.sv
// Circular branch-target trace buffer; reads are indexed newest-first and
// slots not yet written since the last clear read as zero.
module perf_trace_buf
  import otter_perf_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           push,
  input  logic [W-1:0]                   push_data,
  input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx,
  output logic [W-1:0]                   rd_data
);

  localparam int PW = $clog2(TRACE_DEPTH);

  logic [W-1:0]  mem [TRACE_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW:0]   fill_reg;
  logic [PW-1:0] rd_slot;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr_reg <= '0;
      fill_reg   <= '0;
    end else if (push) begin
      wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (fill_reg != (PW+1)'(TRACE_DEPTH))
        fill_reg <= fill_reg + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clr && push)
      mem[wr_ptr_reg] <= push_data;
  end

  // Newest entry sits one slot behind the write pointer
  assign rd_slot = wr_ptr_reg - PW'(1) - rd_idx;
  assign rd_data = ({1'b0, rd_idx} < fill_reg) ? mem[rd_slot] : '0;

endmodule

// File: rtl/otter_perf_monitor.sv
// IOBUS-mapped pipeline performance counters and PC watchpoint for the OTTER.
// Define PERF_TRACE_EN to add the 8-entry branch-target trace at offsets 0x20-0x3C.
module otter_perf_monitor
  import otter_perf_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
  parameter int          CNT_W     = 32
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] PC,
  input  logic        PC_ADV,
  input  logic        LD_USE_STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] PERF_RD,
  output logic        WATCH_HIT
);

  perf_state_t      state_reg;
  logic             en_reg;
  logic             freeze_on_hit_reg;
  logic [31:0]      watch_addr_reg;
  logic [31:0]      hit_limit_reg;
  logic             watch_hit_reg;

  logic             in_win;
  logic [5:0]       off;
  logic             wr_any;
  logic             wr_ctrl;
  logic             clr;
  logic             running;
  logic [NUM_CNT-1:0] evt;
  logic [CNT_W-1:0] cnt [NUM_CNT];
  logic [CNT_W-1:0] hits_next;
  logic             limit_reached;
  logic             freeze;
  logic [31:0]      rd_data;
  logic [31:0]      trace_rd;

  assign in_win  = (IOBUS_ADDR[31:6] == BASE_ADDR[31:6]);
  assign off     = IOBUS_ADDR[5:0];
  assign wr_any  = IOBUS_WR && in_win;
  assign wr_ctrl = wr_any && (off == OFF_CTRL);
  assign clr     = wr_ctrl && IOBUS_OUT[1];
  assign running = (state_reg == RUNNING);

  assign evt[CNT_CYCLES]  = running;
  assign evt[CNT_STALLS]  = running && LD_USE_STALL;
  assign evt[CNT_FLUSHES] = running && BRANCH_TAKEN;
  assign evt[CNT_HITS]    = running && PC_ADV && !LD_USE_STALL && (PC == watch_addr_reg);

  // Saturating counters; a clear in the same cycle as an event wins
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      logic [CNT_W-1:0] count_reg;
      always_ff @(posedge CLK) begin
        if (!RST_N || clr)
          count_reg <= '0;
        else if (evt[gi] && (count_reg != '1))
          count_reg <= count_reg + CNT_W'(1);
      end
      assign cnt[gi] = count_reg;
    end
  endgenerate

  // Value HITS will hold after this edge, so the limit is seen on the reaching edge
  assign hits_next = clr ? '0 :
                     (evt[CNT_HITS] && (cnt[CNT_HITS] != '1)) ? cnt[CNT_HITS] + CNT_W'(1) :
                     cnt[CNT_HITS];
  assign limit_reached = (hit_limit_reg != '0) && (32'(hits_next) == hit_limit_reg);
  assign freeze        = evt[CNT_HITS] && limit_reached && freeze_on_hit_reg;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg         <= DISABLED;
      en_reg            <= 1'b0;
      freeze_on_hit_reg <= 1'b0;
      watch_addr_reg    <= '0;
      hit_limit_reg     <= '0;
      watch_hit_reg     <= 1'b0;
      PERF_RD           <= '0;
    end else begin
      PERF_RD       <= rd_data;
      watch_hit_reg <= clr ? 1'b0 : (watch_hit_reg | limit_reached);
      if (wr_ctrl) begin
        en_reg            <= IOBUS_OUT[0];
        freeze_on_hit_reg <= IOBUS_OUT[2];
      end
      if (wr_any && (off == OFF_WATCH)) watch_addr_reg <= IOBUS_OUT;
      if (wr_any && (off == OFF_LIMIT)) hit_limit_reg  <= IOBUS_OUT;
      case (state_reg)
        DISABLED: if (wr_ctrl && IOBUS_OUT[0]) state_reg <= RUNNING;
        RUNNING: begin
          if (wr_ctrl && !IOBUS_OUT[0]) state_reg <= DISABLED;
          else if (freeze)              state_reg <= FROZEN;
        end
        FROZEN: begin
          if (wr_ctrl && !IOBUS_OUT[0]) state_reg <= DISABLED;
          else if (clr)                 state_reg <= RUNNING;
        end
        default: state_reg <= DISABLED;
      endcase
    end
  end

`ifdef PERF_TRACE_EN
  perf_trace_buf #(.W(32)) u_trace (
    .clk       (CLK),
    .rst_n     (RST_N),
    .clr       (clr),
    .push      (running && BRANCH_TAKEN),
    .push_data (PC),
    .rd_idx    (off[4:2]),
    .rd_data   (trace_rd)
  );
`else
  assign trace_rd = '0;
`endif

  always_comb begin
    rd_data = '0;
    if (in_win) begin
      case (off)
        OFF_CTRL:    rd_data = {29'b0, freeze_on_hit_reg, 1'b0, en_reg};
        OFF_WATCH:   rd_data = watch_addr_reg;
        OFF_LIMIT:   rd_data = hit_limit_reg;
        OFF_CYCLES:  rd_data = 32'(cnt[CNT_CYCLES]);
        OFF_STALLS:  rd_data = 32'(cnt[CNT_STALLS]);
        OFF_FLUSHES: rd_data = 32'(cnt[CNT_FLUSHES]);
        OFF_HITS:    rd_data = 32'(cnt[CNT_HITS]);
        OFF_STATUS:  rd_data = {29'b0, watch_hit_reg, state_reg};
        default:     rd_data = (off[5] && (off[1:0] == 2'b00)) ? trace_rd : '0;
      endcase
    end
  end

  assign WATCH_HIT = watch_hit_reg;

endmodule

// File: tb/tb_otter_perf_monitor.sv
// Randomized self-checking bench for otter_perf_monitor against a per-cycle
// behavioural model of the register map, counters, watchpoint and trace.
module tb_otter_perf_monitor;

  localparam logic [31:0] BASE = 32'h1100_0100;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] PC = '0;
  logic        PC_ADV = 1'b0;
  logic        LD_USE_STALL = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] IOBUS_ADDR = '0;
  logic [31:0] IOBUS_OUT = '0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] PERF_RD;
  logic        WATCH_HIT;

  int n_checks = 0;
  int n_errors = 0;

  otter_perf_monitor dut (
    .CLK(CLK), .RST_N(RST_N), .PC(PC), .PC_ADV(PC_ADV),
    .LD_USE_STALL(LD_USE_STALL), .BRANCH_TAKEN(BRANCH_TAKEN),
    .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT), .IOBUS_WR(IOBUS_WR),
    .PERF_RD(PERF_RD), .WATCH_HIT(WATCH_HIT)
  );

  always #5 CLK = ~CLK;

  // Behavioural model state
  logic [1:0]  m_state;
  logic        m_en, m_frz, m_whit;
  logic [31:0] m_watch, m_limit, m_cyc, m_stall, m_flush, m_hits;
  logic [31:0] m_trace[$];

  function automatic logic [31:0] sat_inc(logic [31:0] v, logic e);
    return (e && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  task automatic model_reset();
    m_state = 2'd0; m_en = 0; m_frz = 0; m_whit = 0;
    m_watch = 0; m_limit = 0; m_cyc = 0; m_stall = 0; m_flush = 0; m_hits = 0;
    m_trace.delete();
  endtask

  // Applies the effect of the coming clock edge given the inputs now on the pins
  task automatic model_tick();
    logic in_win, wr, ctrl_wr, clr, run, hit, reached;
    logic [5:0] off;
    if (!RST_N) begin
      model_reset();
      return;
    end
    in_win  = (IOBUS_ADDR[31:6] == BASE[31:6]);
    off     = IOBUS_ADDR[5:0];
    wr      = IOBUS_WR && in_win;
    ctrl_wr = wr && off == 6'h00;
    clr     = ctrl_wr && IOBUS_OUT[1];
    run     = (m_state == 2'd1);
    hit     = run && PC_ADV && !LD_USE_STALL && PC == m_watch;
    if (clr) begin
      m_cyc = 0; m_stall = 0; m_flush = 0; m_hits = 0; m_whit = 0;
      m_trace.delete();
    end else begin
      m_cyc   = sat_inc(m_cyc, run);
      m_stall = sat_inc(m_stall, run && LD_USE_STALL);
      m_flush = sat_inc(m_flush, run && BRANCH_TAKEN);
      m_hits  = sat_inc(m_hits, hit);
      if (run && BRANCH_TAKEN) begin
        m_trace.push_front(PC);
        if (m_trace.size() > 8) void'(m_trace.pop_back());
      end
    end
    reached = !clr && m_limit != 0 && m_hits == m_limit;
    if (reached) m_whit = 1;
    if (ctrl_wr && !IOBUS_OUT[0]) m_state = 2'd0;
    else if (ctrl_wr && IOBUS_OUT[0] && (clr || m_state == 2'd0)) m_state = 2'd1;
    else if (run && hit && reached && m_frz) m_state = 2'd2;
    if (ctrl_wr) begin m_en = IOBUS_OUT[0]; m_frz = IOBUS_OUT[2]; end
    if (wr && off == 6'h04) m_watch = IOBUS_OUT;
    if (wr && off == 6'h08) m_limit = IOBUS_OUT;
  endtask

  function automatic logic [31:0] model_read(logic [5:0] off);
    int idx;
    case (off)
      6'h00: return {29'b0, m_frz, 1'b0, m_en};
      6'h04: return m_watch;
      6'h08: return m_limit;
      6'h0C: return m_cyc;
      6'h10: return m_stall;
      6'h14: return m_flush;
      6'h18: return m_hits;
      6'h1C: return {29'b0, m_whit, m_state};
      default: begin
`ifdef PERF_TRACE_EN
        if (off[5] && off[1:0] == 2'b00) begin
          idx = int'(off[4:2]);
          if (idx < m_trace.size()) return m_trace[idx];
        end
`else
        idx = 0;
`endif
        return 32'd0;
      end
    endcase
  endfunction

  task automatic step();
    model_tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [5:0] off, input logic [31:0] data);
    IOBUS_ADDR = BASE + {26'b0, off};
    IOBUS_OUT  = data;
    IOBUS_WR   = 1'b1;
    step();
    IOBUS_WR   = 1'b0;
    $display("wr off=%h data=%h", off, data);
  endtask

  task automatic bus_read(input logic [5:0] off, output logic [31:0] got, output logic [31:0] exp);
    IOBUS_ADDR = BASE + {26'b0, off};
    IOBUS_WR   = 1'b0;
    exp = model_read(off);
    step();
    got = PERF_RD;
    $display("rd off=%h data=%h", off, got);
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    RST_N = 1'b0;
    repeat (3) step();
    n_checks++;
    if (PERF_RD !== 32'd0) begin n_errors++; $display("FAIL reset_perf_rd got=%h exp=0", PERF_RD); end
    n_checks++;
    if (WATCH_HIT !== 1'b0) begin n_errors++; $display("FAIL reset_watch_hit got=%b exp=0", WATCH_HIT); end
    RST_N = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus_read(6'(i * 4), got, exp);
      n_checks++;
      if (got !== 32'd0) begin n_errors++; $display("FAIL reset_read off=%0h got=%h exp=0", i * 4, got); end
    end
  endtask

  task automatic test_counting();
    logic [31:0] got, exp;
    int elapsed;
    bus_write(6'h00, 32'h1);
    elapsed = 0;
    LD_USE_STALL = 1'b1;
    repeat (5) begin step(); elapsed++; end
    LD_USE_STALL = 1'b0;
    for (int i = 0; i < 3; i++) begin
      PC = $urandom & 32'hFFFC;
      BRANCH_TAKEN = 1'b1;
      step(); elapsed++;
      BRANCH_TAKEN = 1'b0;
      repeat ($urandom_range(0, 3)) begin step(); elapsed++; end
    end
    bus_write(6'h00, 32'h0);
    elapsed++;
    bus_read(6'h10, got, exp);
    n_checks++;
    if (got !== 32'd5) begin n_errors++; $display("FAIL stalls got=%0d exp=5", got); end
    bus_read(6'h14, got, exp);
    n_checks++;
    if (got !== 32'd3) begin n_errors++; $display("FAIL flushes got=%0d exp=3", got); end
    bus_read(6'h0C, got, exp);
    n_checks++;
    if (got !== 32'(elapsed)) begin n_errors++; $display("FAIL cycles got=%0d exp=%0d", got, elapsed); end
  endtask

  task automatic hit_attempt(input logic stall);
    PC = 32'h010C; PC_ADV = 1'b1; LD_USE_STALL = stall;
    step();
    PC = 32'h0200; PC_ADV = 1'b0; LD_USE_STALL = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_watch_freeze();
    logic [31:0] got, exp, cyc_a;
    bus_write(6'h00, 32'h2);
    bus_write(6'h04, 32'h010C);
    bus_write(6'h08, 32'd2);
    bus_write(6'h00, 32'h5);
    for (int i = 0; i < 3; i++) hit_attempt(1'b0);
    n_checks++;
    if (WATCH_HIT !== 1'b1) begin n_errors++; $display("FAIL watch_hit got=%b exp=1", WATCH_HIT); end
    bus_read(6'h18, got, exp);
    n_checks++;
    if (got !== 32'd2) begin n_errors++; $display("FAIL hits_frozen got=%0d exp=2", got); end
    bus_read(6'h1C, got, exp);
    n_checks++;
    if (got !== 32'h6) begin n_errors++; $display("FAIL status_frozen got=%h exp=6", got); end
    bus_read(6'h0C, cyc_a, exp);
    repeat (4) step();
    bus_read(6'h0C, got, exp);
    n_checks++;
    if (got !== cyc_a) begin n_errors++; $display("FAIL cycles_hold got=%0d exp=%0d", got, cyc_a); end
  endtask

  task automatic test_stall_hit();
    logic [31:0] got, exp;
    bus_write(6'h00, 32'h2);
    bus_write(6'h00, 32'h5);
    hit_attempt(1'b0);
    hit_attempt(1'b1);
    bus_read(6'h18, got, exp);
    n_checks++;
    if (got !== 32'd1) begin n_errors++; $display("FAIL hits_stalled got=%0d exp=1", got); end
    n_checks++;
    if (WATCH_HIT !== 1'b0) begin n_errors++; $display("FAIL watch_early got=%b exp=0", WATCH_HIT); end
    hit_attempt(1'b0);
    bus_read(6'h18, got, exp);
    n_checks++;
    if (got !== 32'd2) begin n_errors++; $display("FAIL hits_after got=%0d exp=2", got); end
    n_checks++;
    if (WATCH_HIT !== 1'b1) begin n_errors++; $display("FAIL watch_after got=%b exp=1", WATCH_HIT); end
  endtask

  task automatic test_saturation();
    logic [31:0] got, exp;
    bus_write(6'h00, 32'h0);
    force dut.g_cnt[0].count_reg = 32'hFFFF_FFFE;
    step();
    release dut.g_cnt[0].count_reg;
    m_cyc = 32'hFFFF_FFFE;
    bus_write(6'h00, 32'h1);
    repeat (3) step();
    bus_write(6'h00, 32'h0);
    bus_read(6'h0C, got, exp);
    n_checks++;
    if (got !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL cycles_sat got=%h exp=ffffffff", got); end
  endtask

  task automatic test_trace();
    logic [31:0] got, exp, newest;
    bus_write(6'h00, 32'h2);
    bus_write(6'h00, 32'h1);
    for (int i = 0; i < 10; i++) begin
      PC = 32'h100 + 32'(i * 4);
      BRANCH_TAKEN = 1'b1;
      step();
    end
    BRANCH_TAKEN = 1'b0;
    bus_write(6'h00, 32'h0);
`ifdef PERF_TRACE_EN
    newest = 32'h124;
`else
    newest = 32'h0;
`endif
    for (int i = 0; i < 8; i++) begin
      bus_read(6'(32 + i * 4), got, exp);
      n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL trace idx=%0d got=%h exp=%h", i, got, exp); end
      if (i == 0) begin
        n_checks++;
        if (got !== newest) begin n_errors++; $display("FAIL trace_newest got=%h exp=%h", got, newest); end
      end
    end
    bus_write(6'h00, 32'h2);
    for (int i = 0; i < 8; i++) begin
      bus_read(6'(32 + i * 4), got, exp);
      n_checks++;
      if (got !== 32'd0) begin n_errors++; $display("FAIL trace_clr idx=%0d got=%h exp=0", i, got); end
    end
  endtask

  task automatic test_random();
    logic [31:0] got, exp;
    logic [5:0] off;
    bus_write(6'h00, 32'h2);
    bus_write(6'h04, 32'h40);
    bus_write(6'h08, 32'($urandom_range(3, 6)));
    bus_write(6'h00, 32'h5);
    for (int c = 0; c < 400; c++) begin
      PC           = 32'h40 + 32'($urandom_range(0, 2) * 4);
      PC_ADV       = $urandom_range(0, 1) == 1;
      LD_USE_STALL = $urandom_range(0, 3) == 0;
      BRANCH_TAKEN = $urandom_range(0, 4) == 0;
      case ($urandom_range(0, 9))
        0: begin
          off = 6'($urandom_range(0, 15) * 4);
          if (off == 6'h04) bus_write(off, 32'h40 + 32'($urandom_range(0, 2) * 4));
          else if (off == 6'h08) bus_write(off, 32'($urandom_range(0, 5)));
          else bus_write(off, 32'($urandom_range(0, 7)));
        end
        1, 2, 3: begin
          off = 6'($urandom_range(0, 15) * 4);
          bus_read(off, got, exp);
          n_checks++;
          if (got !== exp) begin n_errors++; $display("FAIL rand_read off=%h got=%h exp=%h", off, got, exp); end
        end
        default: step();
      endcase
      n_checks++;
      if (WATCH_HIT !== m_whit) begin n_errors++; $display("FAIL rand_watch cyc=%0d got=%b exp=%b", c, WATCH_HIT, m_whit); end
    end
    PC_ADV = 1'b0; LD_USE_STALL = 1'b0; BRANCH_TAKEN = 1'b0;
  endtask

  task automatic test_reset_midrun();
    logic [31:0] got, exp;
    bus_write(6'h00, 32'h2);
    bus_write(6'h08, 32'd1);
    bus_write(6'h04, 32'h300);
    bus_write(6'h00, 32'h1);
    PC = 32'h300; PC_ADV = 1'b1; LD_USE_STALL = 1'b1; BRANCH_TAKEN = 1'b1;
    repeat (2) step();
    LD_USE_STALL = 1'b0;
    step();
    PC_ADV = 1'b0; BRANCH_TAKEN = 1'b0;
    RST_N = 1'b0;
    bus_write(6'h00, 32'h5);
    RST_N = 1'b1;
    n_checks++;
    if (WATCH_HIT !== 1'b0) begin n_errors++; $display("FAIL midrun_watch got=%b exp=0", WATCH_HIT); end
    for (int i = 0; i < 8; i++) begin
      bus_read(6'(i * 4), got, exp);
      n_checks++;
      if (got !== 32'd0) begin n_errors++; $display("FAIL midrun_read off=%0h got=%h exp=0", i * 4, got); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_counting();
    test_watch_freeze();
    test_stall_hit();
    test_saturation();
    test_trace();
    test_random();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
